mat2x2_mac_seq: RTL and testbench



---
 rtl/mat2x2_mac_seq.sv | 132 +++++++++++++
 tb/tb_mat2x2_mac_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mat2x2_mac_seq.sv
// Sequential 2x2 signed fixed-point matrix multiply (C = A*B) on one shared MAC.
// Eight MAC steps per operation; each element is rescaled, then saturated or wrapped.
module mat2x2_mac_seq #(
    parameter int W    = 16,
    parameter int FRAC = 14,
    parameter int SAT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] a11,
    input  logic signed [W-1:0] a12,
    input  logic signed [W-1:0] a21,
    input  logic signed [W-1:0] a22,
    input  logic signed [W-1:0] b11,
    input  logic signed [W-1:0] b12,
    input  logic signed [W-1:0] b21,
    input  logic signed [W-1:0] b22,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] c11,
    output logic signed [W-1:0] c12,
    output logic signed [W-1:0] c21,
    output logic signed [W-1:0] c22,
    output logic                ovf
);

    typedef enum logic [0:0] {IDLE = 1'b0, MAC = 1'b1} state_t;

    localparam logic signed [2*W:0] MAX_S = $signed({{(W+2){1'b0}}, {(W-1){1'b1}}});
    localparam logic signed [2*W:0] MIN_S = $signed({{(W+2){1'b1}}, {(W-1){1'b0}}});

    state_t                state_r;
    logic [2:0]            step_r;
    logic signed [W-1:0]   a_r [4];
    logic signed [W-1:0]   b_r [4];
    logic signed [W-1:0]   c_r [4];
    logic signed [2*W:0]   acc_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  ovf_r;

    logic signed [W-1:0]   mul_a_s;
    logic signed [W-1:0]   mul_b_s;
    logic signed [2*W-1:0] prod_s;
    logic signed [2*W:0]   sum_s;
    logic signed [2*W:0]   shifted_s;
    logic                  oor_s;
    logic signed [W-1:0]   result_s;

    // Clamp to the W-bit range when saturating, otherwise keep the low W bits.
    function automatic logic signed [W-1:0] scale_f(input logic signed [2*W:0] v);
        logic signed [W-1:0] r;
        if (SAT != 0 && v > MAX_S) begin
            r = MAX_S[W-1:0];
        end else if (SAT != 0 && v < MIN_S) begin
            r = MIN_S[W-1:0];
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

    // Operand select and datapath: step[2:1] is the element (row, col), step[0] the k term.
    always_comb begin
        mul_a_s   = a_r[{step_r[2], step_r[0]}];
        mul_b_s   = b_r[{step_r[0], step_r[1]}];
        prod_s    = mul_a_s * mul_b_s;
        sum_s     = acc_r + {prod_s[2*W-1], prod_s};
        shifted_s = sum_s >>> FRAC;
        oor_s     = (shifted_s > MAX_S) || (shifted_s < MIN_S);
        result_s  = scale_f(shifted_s);
    end

    // Control FSM, operand latches, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            step_r  <= 3'd0;
            acc_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_r[i] <= '0;
                b_r[i] <= '0;
                c_r[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r[0] <= a11; a_r[1] <= a12; a_r[2] <= a21; a_r[3] <= a22;
                        b_r[0] <= b11; b_r[1] <= b12; b_r[2] <= b21; b_r[3] <= b22;
                        ovf_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        step_r  <= 3'd0;
                        state_r <= MAC;
                    end
                end
                MAC: begin
                    if (!step_r[0]) begin
                        acc_r <= {prod_s[2*W-1], prod_s};
                    end else begin
                        c_r[step_r[2:1]] <= result_s;
                        ovf_r            <= ovf_r | oor_s;
                        if (step_r == 3'd7) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                    step_r <= step_r + 3'd1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign ovf  = ovf_r;
    assign c11  = c_r[0];
    assign c12  = c_r[1];
    assign c21  = c_r[2];
    assign c22  = c_r[3];

endmodule

// File: tb/tb_mat2x2_mac_seq.sv
// Scoreboard bench for mat2x2_mac_seq: a saturating and a wrapping instance share stimulus;
// expected results are queued at issue time and popped by per-instance monitors on done.
module tb_mat2x2_mac_seq;

    typedef struct packed {
        logic [15:0] c11;
        logic [15:0] c12;
        logic [15:0] c21;
        logic [15:0] c22;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start;
    logic signed [15:0] a11, a12, a21, a22, b11, b12, b21, b22;
    logic busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;
    logic signed [15:0] c11_s, c12_s, c21_s, c22_s, c11_w, c12_w, c21_w, c22_w;

    exp_t q_s[$];
    exp_t q_w[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    mat2x2_mac_seq #(.W(16), .FRAC(14), .SAT(1)) dut_sat (
        .clk(clk), .reset(reset), .start(start),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22),
        .b11(b11), .b12(b12), .b21(b21), .b22(b22),
        .busy(busy_s), .done(done_s),
        .c11(c11_s), .c12(c12_s), .c21(c21_s), .c22(c22_s), .ovf(ovf_s));

    mat2x2_mac_seq #(.W(16), .FRAC(14), .SAT(0)) dut_wrap (
        .clk(clk), .reset(reset), .start(start),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22),
        .b11(b11), .b12(b12), .b21(b21), .b22(b22),
        .busy(busy_w), .done(done_w),
        .c11(c11_w), .c12(c12_w), .c21(c21_w), .c22(c22_w), .ovf(ovf_w));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic compare(input string who, input exp_t e, input exp_t a);
        check({who, ".c11"}, {16'd0, a.c11}, {16'd0, e.c11});
        check({who, ".c12"}, {16'd0, a.c12}, {16'd0, e.c12});
        check({who, ".c21"}, {16'd0, a.c21}, {16'd0, e.c21});
        check({who, ".c22"}, {16'd0, a.c22}, {16'd0, e.c22});
        check({who, ".ovf"}, {31'd0, a.ovf}, {31'd0, e.ovf});
    endtask

    // Monitor for the saturating instance.
    always @(negedge clk) begin
        if (done_s === 1'b1) begin
            done_cnt++;
            if (q_s.size() == 0) check("sat_unexpected_done", 32'd1, 32'd0);
            else compare("sat", q_s.pop_front(), {c11_s, c12_s, c21_s, c22_s, ovf_s});
        end
    end

    // Monitor for the wrapping instance.
    always @(negedge clk) begin
        if (done_w === 1'b1) begin
            if (q_w.size() == 0) check("wrap_unexpected_done", 32'd1, 32'd0);
            else compare("wrap", q_w.pop_front(), {c11_w, c12_w, c21_w, c22_w, ovf_w});
        end
    end

    task automatic set_in(input logic [15:0] x11, x12, x21, x22, y11, y12, y21, y22);
        a11 = x11; a12 = x12; a21 = x21; a22 = x22;
        b11 = y11; b12 = y12; b21 = y21; b22 = y22;
    endtask

    // Waits for done on the saturating instance, bounded; returns the cycles taken.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (done_s !== 1'b1 && cyc < 30);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input exp_t es, input exp_t ew);
        int cyc;
        q_s.push_back(es);
        q_w.push_back(ew);
        pulse_start();
        check({name, "_busy_after_E0"}, {31'd0, busy_s}, 32'd1);
        set_in(16'h1234, 16'h8000, 16'h7FFF, 16'hABCD, 16'h4321, 16'h0F0F, 16'hFFFF, 16'h5555);
        wait_done(cyc);
        check({name, "_latency"}, cyc, 32'd8);
        @(posedge clk); #1;
        check({name, "_done_low_E9"}, {31'd0, done_s}, 32'd0);
        check({name, "_busy_low_E9"}, {31'd0, busy_s}, 32'd0);
    endtask

    initial begin
        int   cyc;
        int   d0;
        exp_t e;
        reset = 1'b1;
        start = 1'b0;
        set_in(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_busy", {31'd0, busy_s}, 32'd0);
        check("reset_done", {31'd0, done_s}, 32'd0);
        check("reset_ovf", {31'd0, ovf_s}, 32'd0);
        check("reset_c11", {16'd0, c11_s}, 32'd0);
        check("reset_c22_wrap", {16'd0, c22_w}, 32'd0);

        // Identity times B
        set_in(16'd16384, 16'd0, 16'd0, 16'd16384, 16'd491, 16'd1638, -16'sd8192, 16'd16384);
        e = {16'd491, 16'd1638, 16'hE000, 16'd16384, 1'b0};
        run_op("ident", e, e);

        // A times identity; inputs scrambled after acceptance
        set_in(16'd16384, 16'd491, 16'd0, 16'd16384, 16'd16384, 16'd0, 16'd0, 16'd16384);
        e = {16'd16384, 16'd491, 16'd0, 16'd16384, 1'b0};
        run_op("a_times_i", e, e);

        // Full-scale positive: saturate vs wrap
        set_in(16'd32767, 16'd32767, 16'd32767, 16'd32767,
               16'd32767, 16'd32767, 16'd32767, 16'd32767);
        run_op("sat", {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1},
                      {16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF8, 1'b1});

        // Negative floor
        set_in(16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0);
        e = {16'hFFFF, 16'd0, 16'd0, 16'd0, 1'b0};
        run_op("neg_floor", e, e);

        // Start while busy is ignored
        set_in(16'd16384, 16'd0, 16'd0, 16'd16384, 16'd100, 16'd200, 16'd300, 16'd400);
        e = {16'd100, 16'd200, 16'd300, 16'd400, 1'b0};
        q_s.push_back(e);
        q_w.push_back(e);
        d0 = done_cnt;
        pulse_start();
        repeat (2) @(posedge clk);
        #1 pulse_start();
        wait_done(cyc);
        repeat (12) @(posedge clk);
        #1 check("single_done_when_busy", done_cnt - d0, 32'd1);

        // Start held high through done: back-to-back
        set_in(16'd16384, 16'd0, 16'd0, 16'd16384, 16'd7, 16'hFFF9, 16'd0, 16'd16384);
        e = {16'd7, 16'hFFF9, 16'd0, 16'd16384, 1'b0};
        q_s.push_back(e); q_s.push_back(e);
        q_w.push_back(e); q_w.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        wait_done(cyc);
        check("b2b_first_latency", cyc, 32'd8);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accepted_E9", {31'd0, busy_s}, 32'd1);
        wait_done(cyc);
        check("b2b_second_latency", cyc, 32'd8);

        // Reset mid-operation aborts with no done
        set_in(16'd32767, 16'd32767, 16'd32767, 16'd32767,
               16'd32767, 16'd32767, 16'd32767, 16'd32767);
        pulse_start();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy_s}, 32'd0);
        check("abort_done", {31'd0, done_s}, 32'd0);
        check("abort_c11", {16'd0, c11_s}, 32'd0);
        check("abort_c12", {16'd0, c12_w}, 32'd0);
        check("abort_ovf", {31'd0, ovf_s}, 32'd0);
        d0 = done_cnt;
        repeat (12) @(posedge clk);
        #1 check("abort_no_done", done_cnt - d0, 32'd0);

        set_in(16'd16384, 16'd0, 16'd0, 16'd16384, 16'd491, 16'd1638, -16'sd8192, 16'd16384);
        e = {16'd491, 16'd1638, 16'hE000, 16'd16384, 1'b0};
        run_op("after_abort", e, e);

        repeat (3) @(posedge clk);
        #1 check("sat_queue_drained", q_s.size(), 32'd0);
        check("wrap_queue_drained", q_w.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
